// File: rtl/floo_vc_input_fifo_if.sv
// floo_vc_input_fifo_if: per-VC handshake bundle between a spill chain, the VC input FIFOs and downstream logic
interface floo_vc_input_fifo_if #(
    parameter int unsigned NumVirtChannels = 2,
    parameter int unsigned Depth = 4,
    parameter type flit_t = logic,
    parameter int unsigned CntWidth = $clog2(Depth + 1)
);
    logic [NumVirtChannels-1:0] valid_i;
    logic [NumVirtChannels-1:0] ready_o;
    flit_t data_i;
    logic [NumVirtChannels-1:0] valid_o;
    logic [NumVirtChannels-1:0] ready_i;
    flit_t [NumVirtChannels-1:0] data_o;
    logic [NumVirtChannels-1:0][CntWidth-1:0] usage_o;
    logic err_o;
    modport master (
        output valid_i, data_i, ready_i,
        input ready_o, valid_o, data_o, usage_o, err_o
    );
    modport slave (
        input valid_i, data_i, ready_i,
        output ready_o, valid_o, data_o, usage_o, err_o
    );
endinterface

// File: rtl/floo_vc_input_fifo.sv
// floo_vc_input_fifo: per-VC input FIFOs fed from one shared flit bus
module floo_vc_input_fifo #(
    parameter int unsigned NumVirtChannels = 2,
    parameter int unsigned Depth = 4,
    parameter type flit_t = logic
) (
    input logic clk_i,
    input logic rst_i,
    floo_vc_input_fifo_if.slave bus
);
    localparam int unsigned CntWidth = $clog2(Depth + 1);
    localparam int unsigned PtrWidth = Depth > 1 ? $clog2(Depth) : 1;
    localparam logic [PtrWidth-1:0] LastPtr = PtrWidth'(Depth - 1);
    localparam logic [CntWidth-1:0] Full = CntWidth'(Depth);
    flit_t mem [NumVirtChannels][Depth];
    logic [PtrWidth-1:0] rptr [NumVirtChannels];
    logic [PtrWidth-1:0] wptr [NumVirtChannels];
    logic [CntWidth-1:0] cnt [NumVirtChannels];
    logic [NumVirtChannels-1:0] push_req, push, pop;
    logic multi, err;
    for (genvar v = 0; v < NumVirtChannels; v++) begin : g_vc
        assign bus.ready_o[v] = cnt[v] != Full;
        assign bus.valid_o[v] = cnt[v] != '0;
        assign bus.data_o[v] = mem[v][rptr[v]];
        assign bus.usage_o[v] = cnt[v];
    end
    // The shared bus carries one flit, so only the lowest requesting VC may take it
    assign push_req = bus.valid_i & bus.ready_o;
    assign push = push_req & (~push_req + NumVirtChannels'(1));
    assign multi = |(push_req & (push_req - NumVirtChannels'(1)));
    assign pop = bus.valid_o & bus.ready_i;
    assign bus.err_o = err;
    always_ff @(posedge clk_i) begin
        for (int v = 0; v < NumVirtChannels; v++)
            if (!rst_i && push[v]) mem[v][wptr[v]] <= bus.data_i;
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int v = 0; v < NumVirtChannels; v++) begin
                rptr[v] <= '0;
                wptr[v] <= '0;
                cnt[v] <= '0;
            end
            err <= 1'b0;
        end else begin
            for (int v = 0; v < NumVirtChannels; v++) begin
                if (push[v]) wptr[v] <= wptr[v] == LastPtr ? '0 : wptr[v] + 1'b1;
                if (pop[v]) rptr[v] <= rptr[v] == LastPtr ? '0 : rptr[v] + 1'b1;
                if (push[v] != pop[v]) cnt[v] <= push[v] ? cnt[v] + 1'b1 : cnt[v] - 1'b1;
            end
            err <= err | multi;
        end
    end
endmodule

// File: tb/tb_floo_vc_input_fifo.sv
// tb_floo_vc_input_fifo: directed stimulus checked against a queue-based model every cycle
module tb_floo_vc_input_fifo;
    logic clk = 1'b0;
    logic rst;
    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;
    typedef logic [7:0] flit_q_t[$];
    flit_q_t q [2];
    bit m_err = 1'b0;
    floo_vc_input_fifo_if #(.NumVirtChannels(2), .Depth(4), .flit_t(logic [7:0])) bus ();
    floo_vc_input_fifo #(.NumVirtChannels(2), .Depth(4), .flit_t(logic [7:0])) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus(bus)
    );
    always #5 clk = ~clk;
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    // Model: a VC accepts while it holds fewer than 4 flits; the lowest requester wins the bus
    initial forever begin
        bit preq [2];
        bit pops [2];
        int nreq;
        @(posedge clk);
        if (rst) begin
            q[0].delete();
            q[1].delete();
            m_err = 1'b0;
        end else begin
            nreq = 0;
            for (int v = 0; v < 2; v++) begin
                preq[v] = bus.valid_i[v] && q[v].size() < 4;
                pops[v] = q[v].size() != 0 && bus.ready_i[v];
                if (preq[v]) nreq++;
            end
            for (int v = 0; v < 2; v++) if (pops[v]) void'(q[v].pop_front());
            if (preq[0]) q[0].push_back(bus.data_i);
            else if (preq[1]) q[1].push_back(bus.data_i);
            if (nreq > 1) m_err = 1'b1;
        end
    end
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            for (int v = 0; v < 2; v++) begin
                check($sformatf("ready_o[%0d]", v), 32'(bus.ready_o[v]), 32'(q[v].size() != 4));
                check($sformatf("valid_o[%0d]", v), 32'(bus.valid_o[v]), 32'(q[v].size() != 0));
                check($sformatf("usage_o[%0d]", v), 32'(bus.usage_o[v]), 32'(q[v].size()));
                if (q[v].size() != 0) check($sformatf("data_o[%0d]", v), 32'(bus.data_o[v]), 32'(q[v][0]));
            end
            check("err_o", 32'(bus.err_o), 32'(m_err));
        end
    end
    initial begin
        rst = 1'b1;
        bus.valid_i = '0;
        bus.ready_i = '0;
        bus.data_i = '0;
        step();
        chk_en = 1'b1;
        step();
        rst = 1'b0;
        check("rst valid_o", 32'(bus.valid_o), 32'h0);
        check("rst ready_o", 32'(bus.ready_o), 32'h3);
        check("rst usage_o", 32'(bus.usage_o), 32'h0);
        check("rst err_o", 32'(bus.err_o), 32'h0);
        for (int i = 0; i < 4; i++) begin
            bus.valid_i = 2'b01;
            bus.data_i = 8'hA0 + 8'(i);
            step();
        end
        bus.valid_i = 2'b00;
        check("fill ready_o", 32'(bus.ready_o), 32'h2);
        check("fill usage0", 32'(bus.usage_o[0]), 32'd4);
        check("fill head", 32'(bus.data_o[0]), 32'hA0);
        bus.valid_i = 2'b01;
        bus.data_i = 8'hEE;
        bus.ready_i = 2'b01;
        step();
        bus.valid_i = 2'b00;
        check("fullpp usage0", 32'(bus.usage_o[0]), 32'd3);
        check("fullpp ready0", 32'(bus.ready_o[0]), 32'd1);
        check("drain A1", 32'(bus.data_o[0]), 32'hA1);
        step();
        check("drain A2", 32'(bus.data_o[0]), 32'hA2);
        step();
        check("drain A3", 32'(bus.data_o[0]), 32'hA3);
        step();
        check("drain empty", 32'(bus.valid_o[0]), 32'd0);
        for (int i = 0; i < 10; i++) begin
            bus.valid_i = 2'b01;
            bus.data_i = 8'h10 + 8'(i);
            step();
            check("stream head", 32'(bus.data_o[0]), 32'h10 + 32'(i));
            check("stream usage0", 32'(bus.usage_o[0]), 32'd1);
        end
        bus.valid_i = 2'b00;
        step();
        bus.ready_i = 2'b00;
        for (int i = 0; i < 4; i++) begin
            bus.valid_i = 2'b10;
            bus.data_i = 8'hB0 + 8'(i);
            step();
        end
        bus.ready_i = 2'b01;
        for (int i = 0; i < 6; i++) begin
            bus.valid_i = 2'b01;
            bus.data_i = 8'h20 + 8'(i);
            step();
            check("indep vc0 head", 32'(bus.data_o[0]), 32'h20 + 32'(i));
        end
        bus.valid_i = 2'b00;
        step();
        check("indep usage1", 32'(bus.usage_o[1]), 32'd4);
        check("indep head1", 32'(bus.data_o[1]), 32'hB0);
        bus.ready_i = 2'b10;
        for (int i = 0; i < 4; i++) begin
            check("vc1 order", 32'(bus.data_o[1]), 32'hB0 + 32'(i));
            step();
        end
        check("vc1 empty", 32'(bus.valid_o[1]), 32'd0);
        bus.ready_i = 2'b00;
        bus.valid_i = 2'b11;
        bus.data_i = 8'h55;
        step();
        bus.valid_i = 2'b00;
        check("proto err", 32'(bus.err_o), 32'd1);
        check("proto usage1", 32'(bus.usage_o[1]), 32'd0);
        check("proto usage0", 32'(bus.usage_o[0]), 32'd1);
        check("proto data0", 32'(bus.data_o[0]), 32'h55);
        step();
        check("proto sticky", 32'(bus.err_o), 32'd1);
        bus.valid_i = 2'b01;
        bus.data_i = 8'h66;
        step();
        bus.valid_i = 2'b00;
        check("pre-rst usage0", 32'(bus.usage_o[0]), 32'd2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst valid_o", 32'(bus.valid_o), 32'h0);
        check("midrst usage_o", 32'(bus.usage_o), 32'h0);
        check("midrst err_o", 32'(bus.err_o), 32'h0);
        bus.ready_i = 2'b11;
        for (int i = 0; i < 3; i++) step();
        check("post-rst valid_o", 32'(bus.valid_o), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
